// File: rtl/crc_7_pkg.sv
// Shared constants and state type for the SD command CRC-7 path.
package crc_7_pkg;

   localparam logic [6:0] CRC7_POLY    = 7'h09;
   localparam int         CRC7_FRAME_W = 40;
   localparam int         CRC7_CNT_W   = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } crc7_state_t;

endpackage

// File: rtl/crc7_step.sv
// Single-bit CRC-7 update, also used by the response-CRC checker.
module crc7_step
   import crc_7_pkg::*;
#(
   parameter logic [6:0] POLY = CRC7_POLY
) (
   input  logic [6:0] crc_in,
   input  logic       data_bit,
   output logic [6:0] crc_out
);

   logic fb;

   assign fb      = data_bit ^ crc_in[6];
   assign crc_out = {crc_in[5:0], 1'b0} ^ (fb ? POLY : 7'h00);

endmodule

// File: rtl/crc_7.sv
// Serial CRC-7 generator for 40-bit SD command frames, MSB first.
//   state | meaning
//   IDLE  | waiting for crc_7_enable; latches the frame on start
//   CALC  | one frame bit per cycle through crc7_step
//   DONE  | result and flag held until crc_7_enable drops
module crc_7
   import crc_7_pkg::*;
#(
   parameter int         DATA_W = CRC7_FRAME_W,
   parameter logic [6:0] POLY   = CRC7_POLY
) (
   input  logic              control_clk_i,
   input  logic              control_rst_i,
   input  logic              crc_7_enable,
   input  logic [DATA_W-1:0] data_crc,
   output logic [6:0]        CRC,
   output logic              flag_crc_done
);

   localparam logic [CRC7_CNT_W-1:0] LAST_BIT = CRC7_CNT_W'(DATA_W - 1);

   crc7_state_t             state, state_nxt;
   logic [DATA_W-1:0]       shift_q, shift_nxt;
   logic [CRC7_CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [6:0]              crc_q, crc_nxt, crc_step;
   logic [6:0]              crc_out_nxt;
   logic                    flag_nxt;

   crc7_step #(.POLY(POLY)) u_step (
      .crc_in   (crc_q),
      .data_bit (shift_q[DATA_W-1]),
      .crc_out  (crc_step)
   );

   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift_q;
      cnt_nxt     = cnt_q;
      crc_nxt     = crc_q;
      crc_out_nxt = CRC;
      flag_nxt    = flag_crc_done;
      case (state)
         IDLE: begin
            if (crc_7_enable) begin
               shift_nxt = data_crc;
               crc_nxt   = 7'h00;
               cnt_nxt   = '0;
               state_nxt = CALC;
            end
         end
         CALC: begin
            // Abort leaves the published result untouched.
            if (!crc_7_enable) begin
               state_nxt = IDLE;
            end else begin
               shift_nxt = {shift_q[DATA_W-2:0], 1'b0};
               crc_nxt   = crc_step;
               cnt_nxt   = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  crc_out_nxt = crc_step;
                  flag_nxt    = 1'b1;
                  state_nxt   = DONE;
               end
            end
         end
         DONE: begin
            if (!crc_7_enable) begin
               flag_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge control_clk_i) begin
      if (control_rst_i) begin
         state         <= IDLE;
         shift_q       <= '0;
         cnt_q         <= '0;
         crc_q         <= 7'h00;
         CRC           <= 7'h00;
         flag_crc_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         shift_q       <= shift_nxt;
         cnt_q         <= cnt_nxt;
         crc_q         <= crc_nxt;
         CRC           <= crc_out_nxt;
         flag_crc_done <= flag_nxt;
      end
   end

endmodule

// File: tb/tb_crc_7.sv
// Bench for crc_7: known SD command CRCs, abort/reset/stability sequences, random frames vs. a division model.
module tb_crc_7;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [39:0] data;
   logic [6:0]  crc;
   logic        flag;

   int checks = 0;
   int errors = 0;
   logic [6:0] last_crc;

   crc_7 dut (
      .control_clk_i (clk),
      .control_rst_i (rst),
      .crc_7_enable  (enable),
      .data_crc      (data),
      .CRC           (crc),
      .flag_crc_done (flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [39:0] frame;
      logic [6:0]  crc;
   } vec_t;

   // Remainder of frame * x^7 divided by x^7 + x^3 + 1 (polynomial long division).
   function automatic logic [6:0] crc7_ref(input logic [39:0] frame);
      logic [46:0] rem;
      rem = {frame, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
      return rem[6:0];
   endfunction

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle; leaves enable low and the DUT idle again.
   task automatic run_frame(input string name, input logic [39:0] frame,
                            input logic [6:0] exp, input bit disturb);
      bit early;
      early  = 1'b0;
      data   = frame;
      enable = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (disturb && i == 20) data = ~frame;
         if (i < 40 && flag) early = 1'b1;
      end
      check({name, " flag_early"}, 40'(early), 40'd0);
      check({name, " flag_k40"}, 40'(flag), 40'd1);
      check({name, " crc"}, 40'(crc), 40'(exp));
      for (int i = 0; i < 2; i++) begin
         data = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
         @(negedge clk);
         check({name, " hold"}, {32'd0, flag, crc}, {32'd0, 1'b1, exp});
      end
      enable = 1'b0;
      @(negedge clk);
      check({name, " release"}, {32'd0, flag, crc}, {32'd0, 1'b0, exp});
      last_crc = exp;
   endtask

   vec_t vecs [5];

   initial begin
      bit bad;
      logic [39:0] f;

      vecs[0] = '{frame: 40'h40_0000_0000, crc: 7'h4A};
      vecs[1] = '{frame: 40'h48_0000_01AA, crc: 7'h43};
      vecs[2] = '{frame: 40'h51_0000_0000, crc: 7'h2A};
      vecs[3] = '{frame: 40'h77_0000_0000, crc: 7'h32};
      vecs[4] = '{frame: 40'h00_0000_0000, crc: 7'h00};

      rst    = 1'b1;
      enable = 1'b1;
      data   = 40'h40_0000_0000;
      repeat (2) @(negedge clk);
      check("reset crc", 40'(crc), 40'd0);
      check("reset flag", 40'(flag), 40'd0);
      enable = 1'b0;
      rst    = 1'b0;
      bad    = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (flag || crc !== 7'h00) bad = 1'b1;
      end
      check("reset no_start", 40'(bad), 40'd0);
      last_crc = 7'h00;

      for (int i = 0; i < 5; i++)
         run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].crc, 1'b0);

      // Abort a CMD0 run at cycle 20; previous result must survive.
      data   = 40'h40_0000_0000;
      enable = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      bad    = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (flag || crc !== last_crc) bad = 1'b1;
      end
      check("abort quiet", 40'(bad), 40'd0);
      run_frame("abort restart", 40'h40_0000_0000, 7'h4A, 1'b0);

      run_frame("stability", 40'h48_0000_01AA, 7'h43, 1'b1);

      for (int n = 0; n < 16; n++) begin
         f = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
         if (n == 0) f = 40'hFF_FFFF_FFFF;
         run_frame($sformatf("rand%0d", n), f, crc7_ref(f), n[0]);
      end

      // Reset in the middle of a calculation.
      data   = 40'h77_0000_0000;
      enable = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midreset state", {32'd0, flag, crc}, 40'd0);
      enable = 1'b0;
      rst    = 1'b0;
      bad    = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (flag || crc !== 7'h00) bad = 1'b1;
      end
      check("midreset quiet", 40'(bad), 40'd0);
      run_frame("after reset", 40'h77_0000_0000, 7'h32, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
